// File: rtl/nested_counter.sv
// ============================================================================
// Module   : nested_counter
// Brief    : Cascaded multi-dimensional loop counter (dimension 0 innermost)
//            with per-dimension wrap pulses, last-tuple flag and one-shot mode.
//            Optional checks: define NESTED_COUNTER_ASSERT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nested_counter #(
  parameter int Bits = 8,
  parameter int Dims = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 load_i,
  input  logic                 one_shot_i,
  input  logic [Dims*Bits-1:0] start_val_i,
  input  logic [Dims*Bits-1:0] end_val_i,
  input  logic [Dims*Bits-1:0] count_by_i,
  output logic [Dims*Bits-1:0] count_o,
  output logic [Dims-1:0]      wrap_o,
  output logic                 last_o,
  output logic                 done_o
);

  logic [Dims*Bits-1:0]      r_count;
  logic [Dims-1:0]           r_wrap;
  logic                      r_done;
  logic [Dims-1:0][Bits:0]   w_sum;
  logic [Dims-1:0]           w_at_end;
  logic [Dims-1:0]           w_adv;

  // Sum is one bit wider than the count so the end test cannot overflow.
  always_comb begin
    w_sum    = '0;
    w_at_end = '0;
    w_adv    = '0;
    for (int k = 0; k < Dims; k++) begin
      w_sum[k]    = {1'b0, r_count[k*Bits +: Bits]} + {1'b0, count_by_i[k*Bits +: Bits]};
      w_at_end[k] = (count_by_i[k*Bits +: Bits] == '0) ||
                    (w_sum[k] > {1'b0, end_val_i[k*Bits +: Bits]});
    end
    w_adv[0] = en_i & ~r_done;
    for (int k = 1; k < Dims; k++) begin
      w_adv[k] = w_adv[k-1] & w_at_end[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      r_count <= start_val_i;
      r_wrap  <= '0;
      r_done  <= 1'b0;
    end else begin
      for (int k = 0; k < Dims; k++) begin
        r_wrap[k] <= w_adv[k] & w_at_end[k];
        if (w_adv[k]) begin
          if (w_at_end[k]) begin
            r_count[k*Bits +: Bits] <= start_val_i[k*Bits +: Bits];
          end else begin
            r_count[k*Bits +: Bits] <= w_sum[k][Bits-1:0];
          end
        end
      end
      // Sticky until load or reset, regardless of later one_shot_i changes.
      if (w_adv[Dims-1] && w_at_end[Dims-1] && one_shot_i) begin
        r_done <= 1'b1;
      end
    end
  end

  assign count_o = r_count;
  assign wrap_o  = r_wrap;
  assign done_o  = r_done;
  assign last_o  = &w_at_end;

`ifdef NESTED_COUNTER_ASSERT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < Dims; k++) begin
        assert (end_val_i[k*Bits +: Bits] >= start_val_i[k*Bits +: Bits])
          else $error("nested_counter: end below start in dimension %0d", k);
        assert ((count_by_i[k*Bits +: Bits] != '0) ||
                (end_val_i[k*Bits +: Bits] == start_val_i[k*Bits +: Bits]))
          else $error("nested_counter: zero step on non-degenerate range in dimension %0d", k);
      end
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_nested_counter.sv
// ============================================================================
// Module   : tb_nested_counter
// Brief    : Directed self-checking bench for nested_counter (three configs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nested_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Config A: Bits=4, Dims=2
  logic       a_rst, a_en, a_load, a_os;
  logic [7:0] a_start, a_end, a_step, a_count;
  logic [1:0] a_wrap;
  logic       a_last, a_done;

  // Config B: Bits=4, Dims=1
  logic       b_rst, b_en, b_load, b_os;
  logic [3:0] b_start, b_end, b_step, b_count;
  logic [0:0] b_wrap;
  logic       b_last, b_done;

  // Config C: Bits=4, Dims=3, middle dimension fixed by zero step
  logic        c_rst, c_en, c_load, c_os;
  logic [11:0] c_start, c_end, c_step, c_count;
  logic [2:0]  c_wrap;
  logic        c_last, c_done;

  nested_counter #(.Bits(4), .Dims(2)) u_a (
    .clk_i(clk), .rst_i(a_rst), .en_i(a_en), .load_i(a_load), .one_shot_i(a_os),
    .start_val_i(a_start), .end_val_i(a_end), .count_by_i(a_step),
    .count_o(a_count), .wrap_o(a_wrap), .last_o(a_last), .done_o(a_done)
  );

  nested_counter #(.Bits(4), .Dims(1)) u_b (
    .clk_i(clk), .rst_i(b_rst), .en_i(b_en), .load_i(b_load), .one_shot_i(b_os),
    .start_val_i(b_start), .end_val_i(b_end), .count_by_i(b_step),
    .count_o(b_count), .wrap_o(b_wrap), .last_o(b_last), .done_o(b_done)
  );

  nested_counter #(.Bits(4), .Dims(3)) u_c (
    .clk_i(clk), .rst_i(c_rst), .en_i(c_en), .load_i(c_load), .one_shot_i(c_os),
    .start_val_i(c_start), .end_val_i(c_end), .count_by_i(c_step),
    .count_o(c_count), .wrap_o(c_wrap), .last_o(c_last), .done_o(c_done)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected traversal of config A from (0,0) with en held.
  logic [7:0] exp_a_cnt  [7] = '{8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h00, 8'h01};
  logic [1:0] exp_a_wrap [7] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00};
  logic       exp_a_last [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    a_rst = 1; a_en = 0; a_load = 0; a_os = 0;
    a_start = 8'h00; a_end = 8'h12; a_step = 8'h11;
    b_rst = 1; b_en = 0; b_load = 0; b_os = 0;
    b_start = 4'd3; b_end = 4'd10; b_step = 4'd3;
    c_rst = 1; c_en = 0; c_load = 0; c_os = 0;
    c_start = 12'h050; c_end = 12'h151; c_step = 12'h101;

    tick();
    check("a_rst_count", a_count, 8'h00);
    check("a_rst_wrap",  a_wrap,  2'b00);
    check("a_rst_done",  a_done,  1'b0);
    check("a_rst_last",  a_last,  1'b0);
    check("b_rst_count", b_count, 4'd3);
    check("c_rst_count", c_count, 12'h050);
    a_rst = 0; b_rst = 0; c_rst = 0;

    // Basic free-running traversal
    a_en = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("a_trav_count[%0d]", i), a_count, exp_a_cnt[i]);
      check($sformatf("a_trav_wrap[%0d]", i),  a_wrap,  exp_a_wrap[i]);
      check($sformatf("a_trav_last[%0d]", i),  a_last,  exp_a_last[i]);
      check($sformatf("a_trav_done[%0d]", i),  a_done,  1'b0);
    end

    // One-shot traversal
    a_en = 0; a_load = 1;
    tick();
    check("a_load_count", a_count, 8'h00);
    a_load = 0; a_os = 1; a_en = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("a_os_count[%0d]", i), a_count, exp_a_cnt[i]);
      check($sformatf("a_os_done[%0d]", i),  a_done,  (i == 5) ? 1'b1 : 1'b0);
    end
    check("a_os_final_wrap", a_wrap, 2'b11);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("a_hold_count[%0d]", i), a_count, 8'h00);
      check($sformatf("a_hold_wrap[%0d]", i),  a_wrap,  2'b00);
      check($sformatf("a_hold_done[%0d]", i),  a_done,  1'b1);
    end
    a_os = 0;
    tick();
    check("a_os_clear_done", a_done, 1'b1);
    check("a_os_clear_count", a_count, 8'h00);
    a_en = 0; a_load = 1;
    tick();
    check("a_reload_done", a_done, 1'b0);
    a_load = 0; a_en = 1;
    tick();
    check("a_reload_step", a_count, 8'h01);

    // Stall: en toggling
    a_en = 0; tick(); check("a_stall0", a_count, 8'h01);
    a_en = 1; tick(); check("a_stall1", a_count, 8'h02);
    a_en = 0; tick(); check("a_stall2", a_count, 8'h02);
    a_en = 1; tick(); check("a_stall3", a_count, 8'h10); check("a_stall3_wrap", a_wrap, 2'b01);
    a_en = 0; tick(); check("a_stall4", a_count, 8'h10); check("a_stall4_wrap", a_wrap, 2'b00);
    a_en = 1; tick(); check("a_stall5", a_count, 8'h11);

    // Load beats enable
    a_load = 1; tick();
    check("a_loaden_count", a_count, 8'h00);
    check("a_loaden_wrap",  a_wrap,  2'b00);
    a_load = 0;
    for (int i = 0; i < 5; i++) tick();
    check("a_pre_rst_count", a_count, 8'h12);
    check("a_pre_rst_last",  a_last,  1'b1);

    // Reset at the final tuple while one-shot would otherwise complete
    a_os = 1; a_rst = 1; tick();
    check("a_midrst_count", a_count, 8'h00);
    check("a_midrst_done",  a_done,  1'b0);
    check("a_midrst_wrap",  a_wrap,  2'b00);
    a_rst = 0; a_en = 0;

    // Non-divisible step
    check("b_last_at3", b_last, 1'b0);
    b_en = 1;
    tick(); check("b_seq6", b_count, 4'd6);  check("b_last6", b_last, 1'b0);
    tick(); check("b_seq9", b_count, 4'd9);  check("b_last9", b_last, 1'b1);
    tick(); check("b_seq3", b_count, 4'd3);  check("b_wrap3", b_wrap, 1'b1);
    tick(); check("b_seq6b", b_count, 4'd6); check("b_wrap6", b_wrap, 1'b0);
    b_en = 0; b_start = 4'd12; b_end = 4'd15; b_step = 4'd3; b_load = 1;
    tick(); check("b_top12", b_count, 4'd12); check("b_top12_last", b_last, 1'b0);
    b_load = 0; b_en = 1;
    tick(); check("b_top15", b_count, 4'd15); check("b_top15_last", b_last, 1'b1);
    tick(); check("b_top_wrap", b_count, 4'd12); check("b_top_wrap_p", b_wrap, 1'b1);
    b_en = 0;

    // Zero step in middle dimension
    c_en = 1;
    tick(); check("c_s1", c_count, 12'h051); check("c_w1", c_wrap, 3'b000);
    tick(); check("c_s2", c_count, 12'h150); check("c_w2", c_wrap, 3'b011);
    tick(); check("c_s3", c_count, 12'h151); check("c_l3", c_last, 1'b1);
    tick(); check("c_s4", c_count, 12'h050); check("c_w4", c_wrap, 3'b111);
    tick(); check("c_s5", c_count, 12'h051); check("c_w5", c_wrap, 3'b000);
    c_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nested_counter.md
# nested_counter

Parametrised multi-dimensional loop counter for address and index generation in the accelerator datapath, e.g. feature-map row/column/channel walks and weight-buffer sweeps. It provides `Dims` cascaded counters with independent start, end and step per dimension. Dimension 0 is innermost. Each dimension carries into the next when it wraps. Per-dimension wrap pulses, a last-tuple flag and a one-shot mode let control FSMs sequence a complete tensor traversal without any external counter glue.

## Interface
- `Bits`, default 8: width of each dimension's count, start, end and step.
- `Dims`, default 3: number of cascaded dimensions, minimum 1.
- `clk_i`, input, 1: clock; all state updates on its rising edge.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `en_i`, input, 1: advance the counter by one step this cycle.
- `load_i`, input, 1: synchronous reload of start values; clears done.
- `one_shot_i`, input, 1: 1 = stop after one full traversal; 0 = free-run.
- `start_val_i`, input, Dims*Bits: packed start values; dimension k occupies bits [k*Bits +: Bits].
- `end_val_i`, input, Dims*Bits: packed inclusive end bounds, same packing.
- `count_by_i`, input, Dims*Bits: packed steps, same packing.
- `count_o`, output, Dims*Bits: packed current counts (registered).
- `wrap_o`, output, Dims: per-dimension registered one-cycle pulse, high in the cycle after dimension k reloaded its start value.
- `last_o`, output, 1: combinational; current tuple is the final tuple of the traversal.
- `done_o`, output, 1: registered; sticky in one-shot mode after traversal completes.

## Operation
- Per-dimension end test: `at_end[k] = (count[k] + step[k]) > end[k]`, evaluated in Bits+1 width so it cannot overflow.
  - The last value visited is the largest start + n*step that is ≤ end.
  - A step that does not divide the range is legal.
  - step = 0 forces `at_end[k] = 1`, so the dimension holds its start value.
- Carry: `adv[0] = en_i & ~done_o`; `adv[k] = adv[k-1] & at_end[k-1]`.
- For each dimension with `adv[k]`: if `at_end[k]`, count[k] ← start[k] and `wrap_o[k]` is set next cycle; otherwise count[k] ← count[k] + step[k], truncated to Bits.
- `last_o` = AND of all `at_end[k]`.
- Traversal complete = `adv[Dims-1] & at_end[Dims-1]`. All dimensions reload start values.
  - `one_shot_i` = 1: `done_o` ← 1. Further `en_i` is ignored, so count and wrap are frozen.
  - `one_shot_i` = 0: `done_o` stays 0 and counting continues from the start tuple.
- Priority is `rst_i` > `load_i` > `en_i`.
  - `rst_i` or `load_i`: count ← start_val_i, `wrap_o` ← 0, `done_o` ← 0.
- Inputs are used combinationally every cycle. Start, end and step must be held stable during a traversal; changes take effect on the next update.
- A start value above its end value is a configuration error; see Configuration. The dimension then wraps on every advance.

## Timing
- Reset values: `count_o` = start_val_i (the value sampled at the reset edge), `wrap_o` = 0, `done_o` = 0. `last_o` follows `count_o` combinationally.
- Latency: `en_i` high at edge N changes `count_o` and `wrap_o` after edge N. One step per enabled cycle; `en_i` may be held high continuously.
- `wrap_o[k]` is high for exactly one cycle per wrap. It is 0 in any cycle following an edge without advance, load or reset.
- `done_o` rises in the same cycle that `count_o` shows the start tuple after the final step.
- `load_i` together with `en_i`: the load wins and no step occurs.
- `rst_i` mid-traversal: state returns to the start tuple at the next edge, with no wrap pulses.
- Changing `one_shot_i` from 1 to 0 while `done_o` = 1 does not clear `done_o`. Only `load_i` or `rst_i` clears it.

## Configuration
- Macro: `NESTED_COUNTER_ASSERT_EN`.
- Defined: a simulation-only clocked assertion checks every dimension k on each edge where `rst_i` = 0. Each violation reports an `$error` naming k.
  - end[k] ≥ start[k].
  - step[k] ≠ 0 unless end[k] == start[k].
- Not defined: no checks are compiled and the logic is identical.
- The block has no runtime assertion-enable port.

## Test plan
- Basic traversal: Bits=4, Dims=2, start {0,0}, end {d1=1, d0=2}, step {1,1}, `en_i` held, `one_shot_i`=0.
  - `count_o` (d1,d0) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(0,0),…
  - `wrap_o[0]` pulses when (1,0) and (0,0) appear; `wrap_o[1]` pulses only on the return to (0,0).
  - `last_o` is high at (1,2).
- One-shot: same setup with `one_shot_i`=1.
  - After (1,2) → (0,0), `done_o`=1 and the count holds (0,0) for 10 more enabled cycles.
  - Then `load_i` clears `done_o` and the next `en_i` gives (0,1).
- Non-divisible step: Dims=1, start 3, end 10, step 3.
  - Sequence 3,6,9,3; `last_o` is high at 9.
  - Bits=4 with start 12, end 15, step 3 gives 12,15,12, with no overflow to 2.
- Stall and priority:
  - `en_i` toggling 1,0,1 advances the count only on the high cycles.
  - `load_i` with `en_i` at (1,1) gives (0,0) with no wrap pulse.
  - `rst_i` at (1,2) gives (0,0), `done_o`=0, `wrap_o`=0.
- Step zero: Dims=3, step[1]=0, start[1]=end[1]=5.
  - Dimension 1 stays at 5; carries pass straight from dimension 0 to dimension 2.
  - `wrap_o[1]` pulses with every `wrap_o[0]`.
- Assertions: with `NESTED_COUNTER_ASSERT_EN` defined, start[0]=4 and end[0]=2 raise `$error` for k=0; without the macro there is no message.
